// File: rtl/axi4l_initiator_if.sv
// AXI4-Lite channel bundle shared between a manager and its interconnect/slave.
interface axi4l_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi4l_initiator.sv
// Single-outstanding req/gnt/rvalid core port to AXI4-Lite manager bridge.
// Define AXI4L_INITIATOR_TIMEOUT_EN to add the response watchdog and DRAIN state.
module axi4l_initiator #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            req_i,
    output logic            gnt_o,
    input  logic            we_i,
    input  logic [DW/8-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW-1:0]   wdata_i,
    output logic            rvalid_o,
    output logic [DW-1:0]   rdata_o,
    output logic            err_o,
    axi4l_if.master         axi
);

`ifdef AXI4L_INITIATOR_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dir_q, dir_d;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`endif

    state_t          state_q, state_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [AW-1:0]   awaddr_q, awaddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic [AW-1:0]   araddr_q, araddr_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            bready_c, rready_c;

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        rvalid_d  = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        gnt_o     = 1'b0;
        bready_c  = 1'b0;
        rready_c  = 1'b0;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
        cnt_d     = cnt_q;
        dir_d     = dir_q;
`endif

        // Address/data valids drop only on their own handshake, in any state.
        if (awvalid_q && axi.awready) awvalid_d = 1'b0;
        if (wvalid_q && axi.wready)   wvalid_d  = 1'b0;
        if (arvalid_q && axi.arready) arvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
                    cnt_d = '0;
                    dir_d = we_i;
`endif
                    if (we_i) begin
                        awaddr_d  = addr_i;
                        wdata_d   = wdata_i;
                        wstrb_d   = be_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        araddr_d  = addr_i;
                        arvalid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                bready_c = 1'b1;
                if (axi.bvalid) begin
                    rvalid_d  = 1'b1;
                    err_d     = (axi.bresp != 2'b00);
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    state_d   = IDLE;
                end
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            READ: begin
                rready_c = 1'b1;
                if (axi.rvalid) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = axi.rdata;
                    err_d     = (axi.rresp != 2'b00);
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
            DRAIN: begin
                // Swallow the late response of the abandoned transaction.
                bready_c = 1'b1;
                rready_c = 1'b1;
                if (dir_q ? axi.bvalid : axi.rvalid) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
            cnt_q     <= '0;
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
`ifdef AXI4L_INITIATOR_TIMEOUT_EN
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
`endif
        end
    end

    assign axi.awaddr  = awaddr_q;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_c;
    assign axi.araddr  = araddr_q;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_c;

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_axi4l_initiator.sv
// Directed bench for axi4l_initiator: table of transactions against a simple timed slave.
module tb_axi4l_initiator;

    logic        clk;
    logic        areset;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    axi4l_if #(.AW(32), .DW(32)) axi_bus ();

    axi4l_initiator #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .aclk     (clk),
        .areset   (areset),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .axi      (axi_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // aw_wait doubles as the AR wait for reads; resp_wait is extra cycles before B/R.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          aw_wait;
        int          w_wait;
        int          resp_wait;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    vec_t rd_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_slave();
        axi_bus.awready = 1'b0;
        axi_bus.wready  = 1'b0;
        axi_bus.arready = 1'b0;
        axi_bus.bvalid  = 1'b0;
        axi_bus.bresp   = 2'b00;
        axi_bus.rvalid  = 1'b0;
        axi_bus.rresp   = 2'b00;
        axi_bus.rdata   = 32'h0;
    endtask

    // Starts at a negedge with the request, returns at the negedge where rvalid_o is seen.
    task automatic run_txn(input vec_t v, input int id);
        int   aw_hs, w_hs, ar_hs, rsp_hs, last;
        logic done;
        aw_hs = -1; w_hs = -1; ar_hs = -1; rsp_hs = -1; done = 1'b0;
        req_i = 1'b1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
        #1 check("gnt", gnt_o, 1);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
            end
            check("rvalid_o", rvalid_o, (rsp_hs >= 0));
            if (rvalid_o) begin
                check("latency", c, v.exp_lat);
                check("err_o", err_o, v.exp_err);
                check("rdata_o", rdata_o, v.exp_rdata);
                $display("txn %0d: we=%0d addr=0x%08h lat=%0d err=%0d rdata=0x%08h",
                         id, v.we, v.addr, c, err_o, rdata_o);
                clear_slave();
                done = 1'b1;
            end else if (rsp_hs >= 0) begin
                done = 1'b1;
            end else begin
                check("rdata_idle", rdata_o, 0);
                check("err_idle", err_o, 0);
                check("awvalid", axi_bus.awvalid, (v.we && aw_hs < 0));
                check("wvalid", axi_bus.wvalid, (v.we && w_hs < 0));
                check("arvalid", axi_bus.arvalid, (!v.we && ar_hs < 0));
                check("bready", axi_bus.bready, v.we);
                check("rready", axi_bus.rready, !v.we);
                if (axi_bus.awvalid) begin
                    check("awaddr", axi_bus.awaddr, v.addr);
                    check("awprot", axi_bus.awprot, 0);
                end
                if (axi_bus.wvalid) begin
                    check("wdata", axi_bus.wdata, v.wdata);
                    check("wstrb", axi_bus.wstrb, v.be);
                end
                if (axi_bus.arvalid) begin
                    check("araddr", axi_bus.araddr, v.addr);
                    check("arprot", axi_bus.arprot, 0);
                end
                last = (aw_hs > w_hs) ? aw_hs : w_hs;
                axi_bus.awready = v.we && (c >= 1 + v.aw_wait);
                axi_bus.wready  = v.we && (c >= 1 + v.w_wait);
                axi_bus.arready = !v.we && (c >= 1 + v.aw_wait);
                axi_bus.bresp   = v.resp;
                axi_bus.bvalid  = v.we && aw_hs >= 0 && w_hs >= 0 && (c > last + v.resp_wait);
                axi_bus.rresp   = v.resp;
                axi_bus.rdata   = v.rdata;
                axi_bus.rvalid  = !v.we && ar_hs >= 0 && (c > ar_hs + v.resp_wait);
                if (axi_bus.awvalid && axi_bus.awready) aw_hs = c;
                if (axi_bus.wvalid && axi_bus.wready)   w_hs  = c;
                if (axi_bus.arvalid && axi_bus.arready) ar_hs = c;
                if (axi_bus.bvalid && axi_bus.bready)   rsp_hs = c;
                if (axi_bus.rvalid && axi_bus.rready)   rsp_hs = c;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL txn_timeout: txn %0d got no completion, required one", id);
        end
    endtask

    initial begin
        //          we    addr          wdata         be    resp   rdata         aw w  rsp lat err   exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0005, 4'hF, 2'b00, 32'h0,        0, 0, 0, 3, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'h0000_000A, 4, 0, 0, 7, 1'b0, 32'h0000_000A};
        vecs[2] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'h3, 2'b00, 32'h0,        3, 0, 0, 6, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0004, 32'h0000_0011, 4'hF, 2'b10, 32'h0,        0, 0, 0, 3, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b11, 32'h1234_5678, 0, 0, 0, 3, 1'b1, 32'h1234_5678};
        vecs[5] = '{1'b1, 32'h0000_0014, 32'hA5A5_0F0F, 4'hC, 2'b00, 32'h0,        2, 4, 1, 8, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 2'b00, 32'h8765_4321, 1, 0, 3, 7, 1'b0, 32'h8765_4321};
        vecs[7] = '{1'b1, 32'h0000_001C, 32'h0000_00FF, 4'h0, 2'b00, 32'h0,        1, 1, 0, 4, 1'b0, 32'h0};
        rd_vec  = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 2'b00, 32'h0000_CAFE, 0, 0, 0, 3, 1'b0, 32'h0000_CAFE};

        areset = 1'b1; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
        clear_slave();
        repeat (2) @(negedge clk);

        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", err_o, 0);
        check("rst_awvalid", axi_bus.awvalid, 0);
        check("rst_wvalid", axi_bus.wvalid, 0);
        check("rst_arvalid", axi_bus.arvalid, 0);
        check("rst_bready", axi_bus.bready, 0);
        check("rst_rready", axi_bus.rready, 0);
        check("rst_awaddr", axi_bus.awaddr, 0);
        check("rst_wdata", axi_bus.wdata, 0);
        check("rst_wstrb", axi_bus.wstrb, 0);
        check("rst_araddr", axi_bus.araddr, 0);

        areset = 1'b0;
        @(negedge clk);

        // Stray B/R beats in IDLE must not be accepted.
        axi_bus.bvalid = 1'b1; axi_bus.rvalid = 1'b1;
        #1;
        check("stray_bready", axi_bus.bready, 0);
        check("stray_rready", axi_bus.rready, 0);
        @(negedge clk);
        check("stray_bready2", axi_bus.bready, 0);
        check("stray_rready2", axi_bus.rready, 0);
        check("stray_rvalid", rvalid_o, 0);
        clear_slave();
        @(negedge clk);

        // Each table entry starts in the completion cycle of the previous one.
        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        @(negedge clk);
        check("post_rvalid", rvalid_o, 0);
        check("post_rdata", rdata_o, 0);
        check("post_err", err_o, 0);

        // Reset in the middle of a write with AW still pending.
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = 32'h77; be_i = 4'hF;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        check("mid_awvalid", axi_bus.awvalid, 1);
        check("mid_awaddr", axi_bus.awaddr, 32'h40);
        #2 areset = 1'b1;
        #1;
        check("arst_awvalid", axi_bus.awvalid, 0);
        check("arst_wvalid", axi_bus.wvalid, 0);
        check("arst_awaddr", axi_bus.awaddr, 0);
        check("arst_wdata", axi_bus.wdata, 0);
        check("arst_wstrb", axi_bus.wstrb, 0);
        check("arst_bready", axi_bus.bready, 0);
        check("arst_rvalid", rvalid_o, 0);
        @(negedge clk);
        areset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("after_rst_rvalid", rvalid_o, 0);
            check("after_rst_awvalid", axi_bus.awvalid, 0);
        end
        run_txn(rd_vec, 100);

`ifdef AXI4L_INITIATOR_TIMEOUT_EN
        @(negedge clk);
        // Read whose R beat never arrives before the watchdog (TIMEOUT=8).
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
        #1 check("to_gnt", gnt_o, 1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_i = 1'b0; addr_i = '0;
                check("to_arvalid", axi_bus.arvalid, 1);
            end
            axi_bus.arready = (c == 1);
            if (c < 9) begin
                check("to_rvalid_wait", rvalid_o, 0);
            end else begin
                check("to_rvalid", rvalid_o, 1);
                check("to_err", err_o, 1);
                check("to_rdata", rdata_o, 0);
            end
        end
        $display("txn 200: timeout read addr=0x00000020 rvalid=%0d err=%0d", rvalid_o, err_o);
        req_i = 1'b1;
        for (int c = 9; c <= 12; c++) begin
            if (c > 9) @(negedge clk);
            #1;
            check("drain_gnt", gnt_o, 0);
            check("drain_rready", axi_bus.rready, 1);
            if (c == 12) begin
                axi_bus.rvalid = 1'b1;
                axi_bus.rdata  = 32'h0000_0BAD;
            end
        end
        @(negedge clk);
        clear_slave();
        #1;
        check("drain_discard", rvalid_o, 0);
        check("drain_exit_gnt", gnt_o, 1);
        @(negedge clk);
        run_txn(rd_vec, 201);
`endif

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
